// File: rtl/ethernet_rx_drain.sv
// MMIO initiator draining RX frames from an Ethernet controller onto a byte-keep stream.
// Optional statistics counters: define ETHERNET_RX_DRAIN_STATS_EN.
module ethernet_rx_drain #(
  parameter int          data_width_p   = 32,
  parameter int          eth_mtu_p      = 2048,
  parameter logic [13:0] rx_size_addr_p = 14'h1010,
  parameter logic [13:0] rx_ack_addr_p  = 14'h1018,
  parameter logic [13:0] rx_buf_base_p  = 14'h0800
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic                                enable_i,
  input  logic                                rx_pending_i,
  output logic [13:0]                         addr_o,
  output logic                                read_en_o,
  output logic                                write_en_o,
  output logic [$clog2(data_width_p/8)-1:0]   op_size_o,
  output logic [data_width_p-1:0]             write_data_o,
  input  logic [data_width_p-1:0]             read_data_i,
  output logic [data_width_p-1:0]             data_o,
  output logic [data_width_p/8-1:0]           keep_o,
  output logic                                last_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                busy_o,
  output logic                                oversize_o,
  output logic [15:0]                         packet_count_o,
  output logic [15:0]                         drop_count_o
);

  localparam int B  = data_width_p / 8;
  localparam int LB = $clog2(B);
  localparam logic [LB-1:0] OP_SIZE = LB[LB-1:0];

  typedef enum logic [2:0] {
    IDLE,
    SIZE_RD,
    SIZE_WAIT,
    DATA_RD,
    DATA_WAIT,
    EMIT,
    ACK,
    HOLDOFF
  } state_t;

  state_t                  state_q, state_d;
  logic [11:0]             size_q;
  logic [11:0]             idx_q;
  logic [data_width_p-1:0] data_q;
  logic                    hold_q;
  logic                    oversize_q;

  logic [11:0]  rd_size;
  logic         size_big;
  logic [11:0]  last_idx;
  logic         is_last;
  logic [13:0]  off;
  logic [LB-1:0] rem;
  logic [B-1:0] tail_keep;

  assign rd_size  = read_data_i[11:0];
  assign size_big = {20'b0, rd_size} > 32'(eth_mtu_p);
  assign last_idx = (size_q - 12'd1) >> LB;
  assign is_last  = (idx_q == last_idx);
  assign off      = {2'b0, idx_q} << LB;
  assign rem      = size_q[LB-1:0];

  assign op_size_o  = OP_SIZE;
  assign data_o     = data_q;
  assign oversize_o = oversize_q;

  // Last beat keeps only the residual bytes; a zero residue means a full word.
  always_comb begin
    tail_keep = '0;
    for (int i = 0; i < B; i++) begin
      tail_keep[i] = (rem == '0) || (i < int'(rem));
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_o       = '0;
    read_en_o    = 1'b0;
    write_en_o   = 1'b0;
    write_data_o = '0;
    valid_o      = 1'b0;
    keep_o       = '0;
    last_o       = 1'b0;
    busy_o       = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (enable_i && rx_pending_i) state_d = SIZE_RD;
      end
      SIZE_RD: begin
        read_en_o = 1'b1;
        addr_o    = rx_size_addr_p;
        state_d   = SIZE_WAIT;
      end
      SIZE_WAIT: begin
        if (rd_size == '0 || size_big) state_d = ACK;
        else                           state_d = DATA_RD;
      end
      DATA_RD: begin
        read_en_o = 1'b1;
        addr_o    = rx_buf_base_p + off;
        state_d   = DATA_WAIT;
      end
      DATA_WAIT: begin
        state_d = EMIT;
      end
      EMIT: begin
        valid_o = 1'b1;
        last_o  = is_last;
        keep_o  = is_last ? tail_keep : '1;
        if (ready_i) state_d = is_last ? ACK : DATA_RD;
      end
      ACK: begin
        write_en_o   = 1'b1;
        addr_o       = rx_ack_addr_p;
        write_data_o = {{(data_width_p-1){1'b0}}, 1'b1};
        state_d      = HOLDOFF;
      end
      HOLDOFF: begin
        if (hold_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      size_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      hold_q     <= 1'b0;
      oversize_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      oversize_q <= (state_q == SIZE_WAIT) && size_big;
      if (state_q == SIZE_WAIT) begin
        size_q <= rd_size;
        idx_q  <= '0;
      end
      if (state_q == DATA_WAIT) data_q <= read_data_i;
      if (state_q == EMIT && ready_i && !is_last) idx_q <= idx_q + 12'd1;
      if (state_q == ACK) hold_q <= 1'b0;
      if (state_q == HOLDOFF) hold_q <= 1'b1;
    end
  end

`ifdef ETHERNET_RX_DRAIN_STATS_EN
  logic [15:0] pkt_q, drop_q;
  logic        deliver;

  assign deliver = (size_q != '0) && ({20'b0, size_q} <= 32'(eth_mtu_p));

  // oversize_q is high exactly during the ACK cycle of a dropped frame.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_q  <= '0;
      drop_q <= '0;
    end else if (state_q == ACK) begin
      if (deliver && pkt_q != 16'hFFFF)     pkt_q  <= pkt_q + 16'd1;
      if (oversize_q && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
    end
  end

  assign packet_count_o = pkt_q;
  assign drop_count_o   = drop_q;
`else
  assign packet_count_o = '0;
  assign drop_count_o   = '0;
`endif

endmodule

// File: tb/tb_ethernet_rx_drain.sv
// Randomized self-checking bench for ethernet_rx_drain.
// Models the controller window and predicts the stream from the frame size rules.
module tb_ethernet_rx_drain;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        enable_i;
  logic        rx_pending_i;
  logic [13:0] addr_o;
  logic        read_en_o;
  logic        write_en_o;
  logic [1:0]  op_size_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i;
  logic [31:0] data_o;
  logic [3:0]  keep_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        oversize_o;
  logic [15:0] packet_count_o;
  logic [15:0] drop_count_o;

  ethernet_rx_drain dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .enable_i       (enable_i),
    .rx_pending_i   (rx_pending_i),
    .addr_o         (addr_o),
    .read_en_o      (read_en_o),
    .write_en_o     (write_en_o),
    .op_size_o      (op_size_o),
    .write_data_o   (write_data_o),
    .read_data_i    (read_data_i),
    .data_o         (data_o),
    .keep_o         (keep_o),
    .last_o         (last_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .busy_o         (busy_o),
    .oversize_o     (oversize_o),
    .packet_count_o (packet_count_o),
    .drop_count_o   (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:511];
  logic [11:0] size_val = '0;
  beat_t       beats[$];
  logic [13:0] rd_addrs[$];
  logic [13:0] wr_addrs[$];
  logic [31:0] wr_data[$];
  int          ov_cnt, busy_cyc, stab_err, conflict;
  int          ready_mode = 0;
  int          exp_pkt = 0;
  int          exp_drop = 0;

  function automatic logic [31:0] lookup(logic [13:0] a);
    if (a == 14'h1010) return {20'h0, size_val};
    if (a >= 14'h0800 && a < 14'h1000) return mem[9'((a - 14'h0800) >> 2)];
    return 32'hDEADBEEF;
  endfunction

  // Controller read port: data returned the cycle after the strobe.
  initial begin
    logic        p;
    logic [13:0] a;
    read_data_i = '0;
    forever begin
      @(negedge clk_i);
      p = read_en_o;
      a = addr_o;
      @(posedge clk_i);
      #1;
      read_data_i = p ? lookup(a) : $urandom;
    end
  end

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (ready_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ($urandom % 3) != 0;
        default: ready_i = 1'b0;
      endcase
    end
  end

  initial begin
    logic        sp;
    logic [31:0] pd;
    logic [3:0]  pk;
    logic        pl;
    sp = 1'b0;
    pd = '0;
    pk = '0;
    pl = 1'b0;
    forever begin
      @(negedge clk_i);
      if (read_en_o) rd_addrs.push_back(addr_o);
      if (write_en_o) begin
        wr_addrs.push_back(addr_o);
        wr_data.push_back(write_data_o);
      end
      if (read_en_o && write_en_o) conflict++;
      if (oversize_o) ov_cnt++;
      if (busy_o) busy_cyc++;
      if (sp && reset_n_i &&
          (!valid_o || data_o !== pd || keep_o !== pk || last_o !== pl))
        stab_err++;
      if (valid_o && ready_i) beats.push_back('{data_o, keep_o, last_o});
      sp = valid_o && !ready_i && reset_n_i;
      pd = data_o;
      pk = keep_o;
      pl = last_o;
    end
  end

  task automatic clear_logs();
    beats.delete();
    rd_addrs.delete();
    wr_addrs.delete();
    wr_data.delete();
    ov_cnt   = 0;
    busy_cyc = 0;
    stab_err = 0;
    conflict = 0;
  endtask

  task automatic setup_frame(int s);
    size_val = 12'(s);
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
  endtask

  // Assumes logs cleared and mem/size set; raises pending and checks the frame.
  task automatic drain_and_check(string name, int s, bit drop_mid, bit chk_busy);
    int n;
    int words;
    int bad;
    int ebusy;
    int ep, ed;
    bit deliver;
    logic [3:0] ek;
    rx_pending_i = 1'b1;
    n = 0;
    while (wr_addrs.size() == 0 && n < 20000) begin
      @(negedge clk_i);
      n++;
      if (drop_mid && beats.size() > 0) begin
        rx_pending_i = 1'b0;
        enable_i     = 1'b0;
      end
    end
    rx_pending_i = 1'b0;
    checks++;
    if (n >= 20000) begin
      errors++;
      $display("FAIL %s timeout: got no ack write, want one", name);
    end
    for (int i = 0; i < 6; i++) @(negedge clk_i);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy_o=%b want 0", name, busy_o);
    end
    checks++;
    if (wr_addrs.size() != 1) begin
      errors++;
      $display("FAIL %s ack_count: got %0d want 1", name, wr_addrs.size());
    end else if (wr_addrs[0] !== 14'h1018 || wr_data[0] !== 32'd1) begin
      errors++;
      $display("FAIL %s ack: addr %h data %h want 1018/1", name, wr_addrs[0], wr_data[0]);
    end
    deliver = (s > 0) && (s <= 2048);
    words   = deliver ? (s + 3) / 4 : 0;
    checks++;
    if (beats.size() != words) begin
      errors++;
      $display("FAIL %s beats: got %0d want %0d", name, beats.size(), words);
    end else begin
      bad = 0;
      for (int i = 0; i < words; i++) begin
        ek = (i == words - 1 && (s % 4) != 0) ? 4'((1 << (s % 4)) - 1) : 4'hF;
        if (beats[i].d !== mem[i] || beats[i].k !== ek || beats[i].l !== (i == words - 1)) begin
          if (bad == 0)
            $display("FAIL %s beat %0d: got %h/%h/%b want %h/%h/%b", name, i,
                     beats[i].d, beats[i].k, beats[i].l, mem[i], ek, (i == words - 1));
          bad++;
        end
      end
      if (bad != 0) errors++;
    end
    bad = 0;
    if (rd_addrs.size() != words + 1) bad = 1;
    else begin
      if (rd_addrs[0] !== 14'h1010) bad = 1;
      for (int i = 0; i < words; i++)
        if (rd_addrs[i+1] !== 14'(32'h0800 + 4 * i)) bad = 1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s reads: got %0d reads want %0d in sequence", name, rd_addrs.size(), words + 1);
    end
    checks++;
    if (ov_cnt != ((s > 2048) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s oversize: got %0d pulses want %0d", name, ov_cnt, (s > 2048) ? 1 : 0);
    end
    checks++;
    if (stab_err != 0 || conflict != 0) begin
      errors++;
      $display("FAIL %s protocol: unstable %0d conflicts %0d want 0/0", name, stab_err, conflict);
    end
    if (chk_busy) begin
      ebusy = 3 * words + 5;
      checks++;
      if (busy_cyc != ebusy) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d want %0d", name, busy_cyc, ebusy);
      end
    end
    if (deliver) exp_pkt++;
    if (s > 2048) exp_drop++;
`ifdef ETHERNET_RX_DRAIN_STATS_EN
    ep = exp_pkt;
    ed = exp_drop;
`else
    ep = 0;
    ed = 0;
`endif
    checks++;
    if (packet_count_o !== 16'(ep) || drop_count_o !== 16'(ed)) begin
      errors++;
      $display("FAIL %s counters: got %0d/%0d want %0d/%0d", name,
               packet_count_o, drop_count_o, ep, ed);
    end
    enable_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_n_i    = 1'b0;
    enable_i     = 1'b1;
    rx_pending_i = 1'b0;
    ready_mode   = 0;
    repeat (3) @(negedge clk_i);
    checks++;
    if ({read_en_o, write_en_o, valid_o, last_o, busy_o, oversize_o} !== 6'b0 ||
        addr_o !== '0 || write_data_o !== '0 || data_o !== '0 || keep_o !== '0 ||
        packet_count_o !== '0 || drop_count_o !== '0) begin
      errors++;
      $display("FAIL reset_values: got addr %h data %h keep %h busy %b want all 0",
               addr_o, data_o, keep_o, busy_o);
    end
    checks++;
    if (op_size_o !== 2'd2) begin
      errors++;
      $display("FAIL op_size: got %0d want 2", op_size_o);
    end
    reset_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_latency();
    logic r1, v4, v5;
    clear_logs();
    setup_frame(8);
    @(posedge clk_i);
    #1;
    rx_pending_i = 1'b1;
    @(negedge clk_i);
    r1 = 1'b0;
    v4 = 1'b0;
    v5 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      if (k == 1) r1 = read_en_o && (addr_o == 14'h1010);
      if (k == 4) v4 = valid_o;
      if (k == 5) v5 = valid_o;
    end
    checks++;
    if (r1 !== 1'b1 || v4 !== 1'b0 || v5 !== 1'b1) begin
      errors++;
      $display("FAIL latency: got rd@1=%b valid@4=%b valid@5=%b want 1/0/1", r1, v4, v5);
    end
    drain_and_check("latency", 8, 1'b0, 1'b1);
  endtask

  task automatic test_frames();
    clear_logs(); setup_frame(60);   drain_and_check("f60", 60, 1'b0, 1'b1);
    clear_logs(); setup_frame(61);   drain_and_check("f61", 61, 1'b0, 1'b1);
    clear_logs(); setup_frame(3000); drain_and_check("over3000", 3000, 1'b0, 1'b1);
    clear_logs(); setup_frame(0);    drain_and_check("zero", 0, 1'b0, 1'b1);
    clear_logs(); setup_frame(2048); drain_and_check("mtu", 2048, 1'b0, 1'b1);
    clear_logs(); setup_frame(2049); drain_and_check("mtu_plus1", 2049, 1'b0, 1'b1);
  endtask

  task automatic test_enable();
    clear_logs();
    setup_frame(40);
    enable_i     = 1'b0;
    rx_pending_i = 1'b1;
    repeat (20) @(negedge clk_i);
    checks++;
    if (busy_cyc != 0 || rd_addrs.size() != 0) begin
      errors++;
      $display("FAIL enable_off: got %0d busy cycles %0d reads want 0/0", busy_cyc, rd_addrs.size());
    end
    rx_pending_i = 1'b0;
    enable_i     = 1'b1;
    clear_logs();
    setup_frame(40);
    drain_and_check("mid_drop", 40, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    int s;
    ready_mode = 1;
    clear_logs(); setup_frame(1514); drain_and_check("bp1514", 1514, 1'b0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      case (t)
        4:       s = $urandom_range(2049, 4095);
        5:       s = $urandom_range(1, 7);
        default: s = $urandom_range(1, 2048);
      endcase
      clear_logs(); setup_frame(s); drain_and_check("rand", s, 1'b0, 1'b0);
    end
    ready_mode = 0;
  endtask

  task automatic test_stall_hold();
    clear_logs();
    setup_frame(12);
    ready_mode   = 2;
    rx_pending_i = 1'b1;
    repeat (60) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b1 || beats.size() != 0 || rd_addrs.size() != 2 || stab_err != 0) begin
      errors++;
      $display("FAIL stall_hold: got valid %b beats %0d reads %0d want 1/0/2",
               valid_o, beats.size(), rd_addrs.size());
    end
    ready_mode = 0;
    drain_and_check("stall_hold", 12, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int n;
    clear_logs();
    setup_frame(100);
    ready_mode   = 0;
    rx_pending_i = 1'b1;
    n = 0;
    while (beats.size() < 7 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    reset_n_i = 1'b0;
    #1;
    checks++;
    if ({read_en_o, write_en_o, valid_o, last_o, busy_o, oversize_o} !== 6'b0 ||
        addr_o !== '0 || data_o !== '0 || keep_o !== '0 ||
        packet_count_o !== '0 || drop_count_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: got busy %b valid %b data %h want 0/0/0", busy_o, valid_o, data_o);
    end
    checks++;
    if (wr_addrs.size() != 0 || beats.size() != 7) begin
      errors++;
      $display("FAIL reset_mid_ack: got %0d writes %0d beats want 0/7", wr_addrs.size(), beats.size());
    end
    exp_pkt  = 0;
    exp_drop = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    clear_logs();
    drain_and_check("redrain", 100, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_frames();
    test_enable();
    test_backpressure();
    test_stall_hold();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
